grayscale_stream_ctrl: RTL and testbench

Flow controller wrapping the fixed-latency, non-stallable grayscale unit. It accepts 24-bit RGB pixels over a valid/ready handshake and feeds them to the grayscale unit. A credit-managed output FIFO absorbs in-flight results so downstream back-pressure never drops data. Each output pixel carries start-of-frame, end-of-line and end-of-frame markers derived from row/column counters. The block sits between the pixel input port and the edge-detection kernel.

---
 rtl/grayscale_stream_ctrl.sv | 176 +++++++++++++++++
 tb/tb_grayscale_stream_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_stream_ctrl.sv
// Valid/ready wrapper around a fixed-latency grayscale unit: credit-based flow control,
// tag pipeline for frame markers, and a small output FIFO that absorbs in-flight results.
module grayscale_stream_ctrl #(
  parameter int P_PIXEL_DEPTH  = 24,
  parameter int P_IMAGE_WIDTH  = 640,
  parameter int P_IMAGE_HEIGHT = 480,
  parameter int P_GRAY_LATENCY = 1
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic                       I_PIXEL_VALID,
  output logic                       O_PIXEL_READY,
  input  logic [P_PIXEL_DEPTH-1:0]   I_PIXEL,
  output logic [P_PIXEL_DEPTH-1:0]   O_GS_PIXEL,
  input  logic [P_PIXEL_DEPTH/3-1:0] I_GS_PIXEL,
  output logic                       O_VALID,
  input  logic                       I_READY,
  output logic [P_PIXEL_DEPTH/3-1:0] O_PIXEL,
  output logic                       O_SOF,
  output logic                       O_EOL,
  output logic                       O_EOF,
  output logic                       O_BUSY
);

  localparam int S  = P_PIXEL_DEPTH / 3;
  localparam int D  = P_GRAY_LATENCY + 2;
  localparam int TL = P_GRAY_LATENCY + 1;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(D);
  localparam int XW = $clog2(P_IMAGE_WIDTH);
  localparam int YW = (P_IMAGE_HEIGHT > 1) ? $clog2(P_IMAGE_HEIGHT) : 1;
  localparam int EW = S + 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [CW-1:0]       credits_r;
  logic [XW-1:0]       col_r;
  logic [YW-1:0]       row_r;
  logic [P_PIXEL_DEPTH-1:0] gs_pixel_r;
  logic [3:0]          tag_r [TL];
  logic [EW-1:0]       mem_r [D];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;

  logic                accept_s;
  logic                pop_s;
  logic                write_s;
  logic                sof_s;
  logic                eol_s;
  logic                eof_s;
  logic [EW-1:0]       head_s;
  logic                head_eof_s;
  logic                last_row_s;

  assign O_PIXEL_READY = (credits_r != {CW{1'b0}}) && (state_r != ST_DRAIN) && !I_RESET;
  assign accept_s      = I_PIXEL_VALID && O_PIXEL_READY;
  assign O_VALID       = (count_r != {CW{1'b0}});
  assign pop_s         = O_VALID && I_READY;
  assign write_s       = tag_r[TL-1][3];

  assign last_row_s = (row_r == YW'(P_IMAGE_HEIGHT - 1));
  assign sof_s      = (row_r == {YW{1'b0}}) && (col_r == {XW{1'b0}});
  assign eol_s      = (col_r == XW'(P_IMAGE_WIDTH - 1));
  assign eof_s      = eol_s && last_row_s;

  // Entry layout is {sof, eol, eof, gray}.
  assign head_s     = mem_r[rd_ptr_r];
  assign head_eof_s = head_s[S];
  assign O_PIXEL    = head_s[S-1:0];
  assign O_SOF      = head_s[S+2];
  assign O_EOL      = head_s[S+1];
  assign O_EOF      = head_s[S];
  assign O_BUSY     = (state_r != ST_IDLE);

  // Frame FSM state register
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame FSM next state; DRAIN blocks new input until the eof pixel leaves
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ACTIVE;
        else          state_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (accept_s && eof_s) state_s = ST_DRAIN;
        else                   state_s = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (pop_s && head_eof_s) state_s = ST_IDLE;
        else                     state_s = ST_DRAIN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Credits: one per FIFO slot, reserved at accept, returned at pop
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      credits_r <= CW'(D);
    end else begin
      case ({accept_s, pop_s})
        2'b10:   credits_r <= credits_r - CW'(1);
        2'b01:   credits_r <= credits_r + CW'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  // Column/row position of the next pixel to be accepted
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      col_r <= {XW{1'b0}};
      row_r <= {YW{1'b0}};
    end else if (accept_s) begin
      if (eol_s) begin
        col_r <= {XW{1'b0}};
        row_r <= last_row_s ? {YW{1'b0}} : row_r + YW'(1);
      end else begin
        col_r <= col_r + XW'(1);
      end
    end
  end

  // Grayscale feed register and marker tags travelling alongside it
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      gs_pixel_r <= {P_PIXEL_DEPTH{1'b0}};
      for (int i = 0; i < TL; i++) tag_r[i] <= 4'b0000;
    end else begin
      if (accept_s) gs_pixel_r <= I_PIXEL;
      tag_r[0] <= accept_s ? {1'b1, sof_s, eol_s, eof_s} : 4'b0000;
      for (int i = 1; i < TL; i++) tag_r[i] <= tag_r[i-1];
    end
  end

  assign O_GS_PIXEL = gs_pixel_r;

  // Output FIFO; a write and a pop on the same edge keep the count unchanged
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < D; i++) mem_r[i] <= {EW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (write_s) begin
        mem_r[wr_ptr_r] <= {tag_r[TL-1][2:0], I_GS_PIXEL};
        wr_ptr_r <= (wr_ptr_r == PW'(D - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(D - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_grayscale_stream_ctrl.sv
// Directed bench for grayscale_stream_ctrl at W=4, H=2, one-stage grayscale unit.
module tb_grayscale_stream_ctrl;

  logic        I_CLK;
  logic        I_RESET;
  logic        I_PIXEL_VALID;
  logic        O_PIXEL_READY;
  logic [23:0] I_PIXEL;
  logic [23:0] O_GS_PIXEL;
  logic [7:0]  I_GS_PIXEL;
  logic        O_VALID;
  logic        I_READY;
  logic [7:0]  O_PIXEL;
  logic        O_SOF, O_EOL, O_EOF, O_BUSY;

  int checks = 0;
  int errors = 0;

  logic [7:0] stub_r;
  logic [7:0] real_r;
  logic       use_real;

  grayscale_stream_ctrl #(
    .P_PIXEL_DEPTH (24),
    .P_IMAGE_WIDTH (4),
    .P_IMAGE_HEIGHT(2),
    .P_GRAY_LATENCY(1)
  ) dut (
    .I_CLK        (I_CLK),
    .I_RESET      (I_RESET),
    .I_PIXEL_VALID(I_PIXEL_VALID),
    .O_PIXEL_READY(O_PIXEL_READY),
    .I_PIXEL      (I_PIXEL),
    .O_GS_PIXEL   (O_GS_PIXEL),
    .I_GS_PIXEL   (I_GS_PIXEL),
    .O_VALID      (O_VALID),
    .I_READY      (I_READY),
    .O_PIXEL      (O_PIXEL),
    .O_SOF        (O_SOF),
    .O_EOL        (O_EOL),
    .O_EOF        (O_EOF),
    .O_BUSY       (O_BUSY)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Stub returns R one cycle later; the "real" unit is a BT.601-style weighted sum.
  always_ff @(posedge I_CLK) begin
    stub_r <= O_GS_PIXEL[23:16];
    real_r <= 8'((16'(O_GS_PIXEL[23:16]) * 16'd77 + 16'(O_GS_PIXEL[15:8]) * 16'd150
                 + 16'(O_GS_PIXEL[7:0]) * 16'd29) >> 8);
  end
  assign I_GS_PIXEL = use_real ? real_r : stub_r;

  typedef struct {
    logic       vld;
    logic [7:0] r;
    logic       rdy;
    logic       ov;
    logic [7:0] pix;
    logic       sof, eol, eof;
    logic       prdy;
    logic       busy;
  } vec_t;

  vec_t tab [26];

  function automatic vec_t mk(logic vld, logic [7:0] r, logic rdy, logic ov, logic [7:0] pix,
                              logic sof, logic eol, logic eof, logic prdy, logic busy);
    vec_t v;
    v.vld = vld; v.r = r; v.rdy = rdy; v.ov = ov; v.pix = pix;
    v.sof = sof; v.eol = eol; v.eof = eof; v.prdy = prdy; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    I_RESET = 1'b1; I_PIXEL_VALID = 1'b0; I_READY = 1'b0; I_PIXEL = 24'h0;
    repeat (2) @(posedge I_CLK);
    #1;
    I_RESET = 1'b0;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      I_PIXEL_VALID = tab[i].vld;
      I_PIXEL       = {tab[i].r, 8'h55, 8'hAA};
      I_READY       = tab[i].rdy;
      #1;
      chk("ovalid", i, O_VALID, tab[i].ov);
      chk("pready", i, O_PIXEL_READY, tab[i].prdy);
      chk("busy", i, O_BUSY, tab[i].busy);
      if (tab[i].ov) begin
        chk("opixel", i, O_PIXEL, tab[i].pix);
        chk("markers", i, {O_SOF, O_EOL, O_EOF}, {tab[i].sof, tab[i].eol, tab[i].eof});
      end
      @(posedge I_CLK); #1;
    end
  endtask

  task automatic push(input logic [7:0] r);
    logic ok;
    ok = 1'b0;
    I_PIXEL = {r, 8'h55, 8'hAA};
    I_PIXEL_VALID = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      #1;
      ok = O_PIXEL_READY;
      @(posedge I_CLK); #1;
    end
    chk("push_accept", r, ok, 1);
  endtask

  initial begin
    int          sent, recv, maxout, acc, got;
    logic [10:0] q[$];
    logic [10:0] e;
    use_real = 1'b0;

    // Reset state, checked while reset is still held
    I_RESET = 1'b1; I_PIXEL_VALID = 1'b0; I_READY = 1'b0; I_PIXEL = 24'h0;
    #1;
    chk("rst_ovalid", 0, O_VALID, 0);
    chk("rst_busy", 0, O_BUSY, 0);
    chk("rst_gs", 0, O_GS_PIXEL, 0);
    chk("rst_opixel", 0, {O_SOF, O_EOL, O_EOF, O_PIXEL}, 0);
    chk("rst_pready", 0, O_PIXEL_READY, 0);

    // Streaming frame, I_READY high: credits give 3 accepts per 4-cycle credit loop
    tab[0]  = mk(1, 8'h10, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    tab[1]  = mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 0, 1, 1);
    tab[2]  = mk(1, 8'h12, 1, 0, 8'h00, 0, 0, 0, 1, 1);
    tab[3]  = mk(1, 8'h13, 1, 1, 8'h10, 1, 0, 0, 0, 1);
    tab[4]  = mk(1, 8'h13, 1, 1, 8'h11, 0, 0, 0, 1, 1);
    tab[5]  = mk(1, 8'h14, 1, 1, 8'h12, 0, 0, 0, 1, 1);
    tab[6]  = mk(1, 8'h15, 1, 0, 8'h00, 0, 0, 0, 1, 1);
    tab[7]  = mk(1, 8'h16, 1, 1, 8'h13, 0, 1, 0, 0, 1);
    tab[8]  = mk(1, 8'h16, 1, 1, 8'h14, 0, 0, 0, 1, 1);
    tab[9]  = mk(1, 8'h17, 1, 1, 8'h15, 0, 0, 0, 1, 1);
    tab[10] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 1);
    tab[11] = mk(0, 8'h00, 1, 1, 8'h16, 0, 0, 0, 0, 1);
    tab[12] = mk(0, 8'h00, 1, 1, 8'h17, 0, 1, 1, 0, 1);
    tab[13] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 0);
    // Stall from the start, then release
    tab[14] = mk(1, 8'h10, 0, 0, 8'h00, 0, 0, 0, 1, 0);
    tab[15] = mk(1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    tab[16] = mk(1, 8'h12, 0, 0, 8'h00, 0, 0, 0, 1, 1);
    tab[17] = mk(1, 8'h13, 0, 1, 8'h10, 1, 0, 0, 0, 1);
    tab[18] = mk(1, 8'h13, 0, 1, 8'h10, 1, 0, 0, 0, 1);
    tab[19] = mk(1, 8'h13, 0, 1, 8'h10, 1, 0, 0, 0, 1);
    tab[20] = mk(1, 8'h13, 1, 1, 8'h10, 1, 0, 0, 0, 1);
    tab[21] = mk(1, 8'h13, 1, 1, 8'h11, 0, 0, 0, 1, 1);
    tab[22] = mk(1, 8'h14, 1, 1, 8'h12, 0, 0, 0, 1, 1);
    tab[23] = mk(1, 8'h15, 1, 0, 8'h00, 0, 0, 0, 1, 1);
    tab[24] = mk(1, 8'h16, 1, 1, 8'h13, 0, 1, 0, 0, 1);
    tab[25] = mk(1, 8'h16, 1, 1, 8'h14, 0, 0, 0, 1, 1);

    repeat (2) @(posedge I_CLK);
    #1;
    I_RESET = 1'b0;
    run_rows(0, 13);

    do_reset();
    run_rows(14, 25);

    // DRAIN: input held valid after the eof accept must stay blocked until the eof pop
    do_reset();
    I_READY = 1'b1;
    for (int p = 0; p < 8; p++) push(8'(8'h10 + p));
    I_READY = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("drain_pready", t, O_PIXEL_READY, 0);
      @(posedge I_CLK); #1;
    end
    chk("drain_head", 0, {O_VALID, O_PIXEL}, {1'b1, 8'h16});
    I_READY = 1'b1;
    got = 0;
    for (int t = 0; t < 10 && got == 0; t++) begin
      #1;
      chk("drain_pready_hold", t, O_PIXEL_READY, 0);
      got = (O_VALID && O_EOF) ? 1 : 0;
      @(posedge I_CLK); #1;
    end
    chk("drain_eof_seen", 0, got, 1);
    chk("drain_release", 0, {O_PIXEL_READY, O_BUSY}, 2'b10);
    push(8'h20);
    I_PIXEL_VALID = 1'b0;
    got = 0;
    for (int t = 0; t < 6 && got == 0; t++) begin
      #1;
      got = O_VALID ? 1 : 0;
      if (got == 0) begin @(posedge I_CLK); end
    end
    chk("drain_next_seen", 0, got, 1);
    chk("drain_next_sof", 0, {O_SOF, O_PIXEL}, {1'b1, 8'h20});

    // Random back-pressure over three frames against a scoreboard
    do_reset();
    sent = 0; recv = 0; maxout = 0;
    for (int cyc = 0; cyc < 800 && recv < 24; cyc++) begin
      I_READY       = 1'($urandom_range(0, 1));
      I_PIXEL_VALID = (sent < 24);
      I_PIXEL       = {8'(sent), 8'h55, 8'hAA};
      #1;
      if (O_VALID && I_READY) begin
        chk("rnd_nonempty", recv, (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_data", recv, {O_SOF, O_EOL, O_EOF, O_PIXEL}, e);
        end
        recv++;
      end
      if (I_PIXEL_VALID && O_PIXEL_READY) begin
        acc = sent % 4;
        got = (sent / 4) % 2;
        q.push_back({(acc == 0 && got == 0), (acc == 3), (acc == 3 && got == 1), 8'(sent)});
        sent++;
      end
      if (sent - recv > maxout) maxout = sent - recv;
      @(posedge I_CLK); #1;
    end
    I_PIXEL_VALID = 1'b0;
    chk("rnd_recv", 0, recv, 24);
    chk("rnd_inflight_max", 0, (maxout <= 3), 1);

    // Asynchronous reset with pixels buffered
    do_reset();
    I_READY = 1'b1;
    for (int p = 0; p < 5; p++) push(8'(8'h30 + p));
    I_PIXEL_VALID = 1'b0;
    I_READY = 1'b0;
    repeat (2) begin @(posedge I_CLK); end
    #1;
    chk("mid_buffered", 0, O_VALID, 1);
    I_RESET = 1'b1;
    #1;
    chk("mid_rst_out", 0, {O_VALID, O_SOF, O_EOL, O_EOF, O_PIXEL}, 0);
    chk("mid_rst_busy", 0, {O_BUSY, O_PIXEL_READY}, 0);
    chk("mid_rst_gs", 0, O_GS_PIXEL, 0);
    @(posedge I_CLK); #1;
    I_RESET = 1'b0;
    acc = 0;
    for (int t = 0; t < 6; t++) begin
      I_PIXEL = {8'(8'h40 + acc), 8'h55, 8'hAA};
      I_PIXEL_VALID = 1'b1;
      #1;
      if (O_PIXEL_READY) acc++;
      @(posedge I_CLK); #1;
    end
    I_PIXEL_VALID = 1'b0;
    chk("mid_credits", 0, acc, 3);
    chk("mid_first_sof", 0, {O_VALID, O_SOF, O_PIXEL}, {2'b11, 8'h40});

    // Real grayscale arithmetic, 2-edge latency from accept
    do_reset();
    use_real = 1'b1;
    I_READY = 1'b1;
    I_PIXEL = {8'hFF, 8'h7F, 8'h00};
    I_PIXEL_VALID = 1'b1;
    #1;
    chk("gray_pready", 0, O_PIXEL_READY, 1);
    @(posedge I_CLK); #1;
    I_PIXEL_VALID = 1'b0;
    chk("gray_lat1", 0, O_VALID, 0);
    @(posedge I_CLK); #1;
    chk("gray_lat2", 0, O_VALID, 0);
    @(posedge I_CLK); #1;
    chk("gray_out", 0, {O_VALID, O_PIXEL}, {1'b1, 8'd151});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
